// File: rtl/ex_stage_pkg.sv
// Shared EX-stage definitions: bus widths, opcode/exception encodings,
// MDU state encoding and the EX/MEM pipeline register payload.
package ex_stage_pkg;

    localparam int unsigned WORD_DATA_W = 32;
    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned MDU_OP_W    = 2;
    localparam int unsigned MEM_OP_W    = 2;
    localparam int unsigned CTRL_OP_W   = 2;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned ISA_EXP_W   = 3;
    localparam int unsigned MDU_W       = 32;
    localparam int unsigned MDU_CNT_W   = 5;

    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDS = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUBS = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHRL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'd9;

    localparam logic [MDU_OP_W-1:0] MDU_OP_NONE = 2'd0;
    localparam logic [MDU_OP_W-1:0] MDU_OP_MULU = 2'd1;
    localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU = 2'd2;
    localparam logic [MDU_OP_W-1:0] MDU_OP_REMU = 2'd3;

    localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP   = 3'd0;
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW = 3'd3;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [MEM_OP_W-1:0]    mem_op;
        logic [WORD_DATA_W-1:0] mem_wr_data;
        logic [WORD_DATA_W-1:0] result;
        logic [CTRL_OP_W-1:0]   ctrl_op;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [ISA_EXP_W-1:0]   exp_code;
    } ex_mem_t;

    // Empty EX/MEM slot: nothing valid, no GPR write, no memory access.
    function automatic ex_mem_t ex_mem_bubble();
        ex_mem_t b;
        b         = '0;
        b.gpr_we_ = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative unsigned multiply/divide unit: one bit per cycle, shift-add
// multiply and restoring shift-subtract divide.
module ex_mdu
    import ex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                stall,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [MDU_W-1:0]    a,
    input  logic [MDU_W-1:0]    b,
    output logic                busy,
    output logic                done,
    output logic [MDU_W-1:0]    result
);

    mdu_state_e             state;
    mdu_state_e             state_next;
    logic                   load;
    logic [MDU_CNT_W-1:0]   cnt;
    logic [MDU_OP_W-1:0]    op_q;
    // acc: product (MULU) or partial remainder (DIVU/REMU)
    // opa: shifted multiplicand or dividend/quotient; opb: multiplier or divisor
    logic [MDU_W-1:0]       acc;
    logic [MDU_W-1:0]       opa;
    logic [MDU_W-1:0]       opb;
    logic [MDU_W:0]         trial;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    busy       = 1'b1;
                    state_next = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                busy = 1'b1;
                if (cnt == MDU_CNT_W'(MDU_W - 1)) begin
                    state_next = MDU_DONE;
                end
            end
            MDU_DONE: begin
                done = 1'b1;
                if (!stall) begin
                    state_next = MDU_IDLE;
                end
            end
            default: state_next = MDU_IDLE;
        endcase
        if (flush) begin
            state_next = MDU_IDLE;
        end
    end

    // Remainder shifted left with the next dividend bit, minus divisor.
    assign trial = {acc, opa[MDU_W-1]} - {1'b0, opb};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= MDU_OP_NONE;
            acc  <= '0;
            opa  <= '0;
            opb  <= '0;
        end else if (load) begin
            cnt  <= '0;
            op_q <= op;
            acc  <= '0;
            opa  <= a;
            opb  <= b;
        end else if (state == MDU_BUSY) begin
            cnt <= cnt + MDU_CNT_W'(1);
            if (op_q == MDU_OP_MULU) begin
                acc <= acc + (opb[0] ? opa : '0);
                opa <= opa << 1;
                opb <= opb >> 1;
            end else if (!trial[MDU_W]) begin
                acc <= trial[MDU_W-1:0];
                opa <= {opa[MDU_W-2:0], 1'b1};
            end else begin
                acc <= {acc[MDU_W-2:0], opa[MDU_W-1]};
                opa <= {opa[MDU_W-2:0], 1'b0};
            end
        end
    end

    assign result = (op_q == MDU_OP_DIVU) ? opa : acc;

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: integer ALU, iterative MDU and the EX/MEM register.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    input  logic [WORD_ADDR_W-1:0] id_pc,
    input  logic                   id_en,
    input  logic [ALU_OP_W-1:0]    id_alu_op,
    input  logic [WORD_DATA_W-1:0] id_alu_in_0,
    input  logic [WORD_DATA_W-1:0] id_alu_in_1,
    input  logic [MDU_OP_W-1:0]    id_mdu_op,
    input  logic                   id_br_flag,
    input  logic [MEM_OP_W-1:0]    id_mem_op,
    input  logic [WORD_DATA_W-1:0] id_mem_wr_data,
    input  logic [CTRL_OP_W-1:0]   id_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  id_dst_addr,
    input  logic                   id_gpr_we_,
    input  logic [ISA_EXP_W-1:0]   id_exp_code,
    output logic [WORD_DATA_W-1:0] fwd_data,
    output logic [WORD_ADDR_W-1:0] ex_pc,
    output logic                   ex_en,
    output logic                   ex_br_flag,
    output logic [MEM_OP_W-1:0]    ex_mem_op,
    output logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    output logic [CTRL_OP_W-1:0]   ex_ctrl_op,
    output logic [REG_ADDR_W-1:0]  ex_dst_addr,
    output logic                   ex_gpr_we_,
    output logic [ISA_EXP_W-1:0]   ex_exp_code,
    output logic [WORD_DATA_W-1:0] ex_out
);

    logic [WORD_DATA_W-1:0] alu_out;
    logic                   alu_ovf;
    logic [WORD_DATA_W-1:0] sum;
    logic [WORD_DATA_W-1:0] diff;
    logic                   mdu_start;
    logic                   mdu_done;
    logic [MDU_W-1:0]       mdu_result;
    ex_mem_t                ex_d;
    ex_mem_t                ex_q;

    assign mdu_start = id_en & (id_mdu_op != MDU_OP_NONE) & ~stall & ~flush;

    ex_mdu u_mdu (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .stall  (stall),
        .start  (mdu_start),
        .op     (id_mdu_op),
        .a      (id_alu_in_0),
        .b      (id_alu_in_1),
        .busy   (busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    assign sum  = id_alu_in_0 + id_alu_in_1;
    assign diff = id_alu_in_0 - id_alu_in_1;

    // Signed overflow: operands agree (add) / differ (sub) in sign and the result sign flips.
    always_comb begin
        alu_out = id_alu_in_0;
        alu_ovf = 1'b0;
        case (id_alu_op)
            ALU_OP_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
            ALU_OP_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
            ALU_OP_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
            ALU_OP_ADDS: begin
                alu_out = sum;
                alu_ovf = (id_alu_in_0[WORD_DATA_W-1] == id_alu_in_1[WORD_DATA_W-1]) &&
                          (sum[WORD_DATA_W-1] != id_alu_in_0[WORD_DATA_W-1]);
            end
            ALU_OP_ADDU: alu_out = sum;
            ALU_OP_SUBS: begin
                alu_out = diff;
                alu_ovf = (id_alu_in_0[WORD_DATA_W-1] != id_alu_in_1[WORD_DATA_W-1]) &&
                          (diff[WORD_DATA_W-1] != id_alu_in_0[WORD_DATA_W-1]);
            end
            ALU_OP_SUBU: alu_out = diff;
            ALU_OP_SHRL: alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
            ALU_OP_SHLL: alu_out = id_alu_in_0 << id_alu_in_1[4:0];
            default:     alu_out = id_alu_in_0;
        endcase
    end

    assign fwd_data = mdu_done ? mdu_result : alu_out;

    // Next EX/MEM content; a busy MDU inserts a bubble.
    always_comb begin
        ex_d             = ex_mem_bubble();
        if (!busy) begin
            ex_d.pc          = id_pc;
            ex_d.en          = id_en;
            ex_d.br_flag     = id_br_flag;
            ex_d.mem_op      = id_mem_op;
            ex_d.mem_wr_data = id_mem_wr_data;
            ex_d.result      = fwd_data;
            ex_d.ctrl_op     = id_ctrl_op;
            ex_d.dst_addr    = id_dst_addr;
            ex_d.gpr_we_     = id_gpr_we_;
            ex_d.exp_code    = id_exp_code;
            if (id_exp_code == ISA_EXP_NO_EXP && id_en && alu_ovf && !mdu_done) begin
                ex_d.exp_code = ISA_EXP_OVERFLOW;
                ex_d.gpr_we_  = 1'b1;
                ex_d.mem_op   = MEM_OP_NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_q <= ex_mem_bubble();
        end else if (!stall) begin
            ex_q <= ex_d;
        end
    end

    assign ex_pc          = ex_q.pc;
    assign ex_en          = ex_q.en;
    assign ex_br_flag     = ex_q.br_flag;
    assign ex_mem_op      = ex_q.mem_op;
    assign ex_mem_wr_data = ex_q.mem_wr_data;
    assign ex_ctrl_op     = ex_q.ctrl_op;
    assign ex_dst_addr    = ex_q.dst_addr;
    assign ex_gpr_we_     = ex_q.gpr_we_;
    assign ex_exp_code    = ex_q.exp_code;
    assign ex_out         = ex_q.result;

endmodule
